// File: rtl/traffic_pkg.sv
// Shared types and default parameter values for the pedestrian-request front end
// that feeds traffic_light.
package traffic_pkg;

    typedef enum logic [1:0] {
        PR_IDLE     = 2'd0,
        PR_PENDING  = 2'd1,
        PR_FIRE     = 2'd2,
        PR_COOLDOWN = 2'd3
    } pr_state_t;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int COOLDOWN_CYCLES_DEF = 512;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ped_request_debounce.sv
// Push-button synchronizer followed by a stability counter; dout only moves
// after DEBOUNCE_CYCLES consecutive samples disagree with it.
module debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   bs;

    assign bs = sync[SYNC_STAGES-1];

    // Synchronizer shift and debounce counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            if (bs == dout) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                dout <= bs;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ped_request.sv
// Pedestrian request front end: debounced button, yellow hold, one-cycle pass
// pulse to traffic_light and a post-pulse cooldown.
module ped_request
    import traffic_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       R,
    input  logic       G,
    input  logic       Y,
    output logic       pass,
    output logic       req_pending,
    output logic [7:0] press_cnt
);
    localparam int CDW   = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam int ARM_N = SYNC_STAGES + DEBOUNCE_CYCLES;
    localparam int AW    = $clog2(ARM_N + 1);

    pr_state_t      state;
    logic           db;
    logic           db_q;
    logic           armed;
    logic [AW-1:0]  arm_cnt;
    logic [CDW-1:0] cd;
    logic           press;
    logic [2:0]     lamps;

    debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk (clk),
        .rst (rst),
        .din (btn),
        .dout(db)
    );

    assign press = db & ~db_q & armed;
    assign lamps = {G, Y, R};

    // Edge detect, and arming: a button held through reset must be seen
    // released (db low longer than a full press latency) before it counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_q    <= 1'b0;
            arm_cnt <= '0;
            armed   <= 1'b0;
        end else begin
            db_q <= db;
            if (db) begin
                arm_cnt <= '0;
            end else if (arm_cnt == AW'(ARM_N)) begin
                armed <= 1'b1;
            end else begin
                arm_cnt <= arm_cnt + 1'b1;
            end
        end
    end

    // Request FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= PR_IDLE;
            cd          <= '0;
            pass        <= 1'b0;
            req_pending <= 1'b0;
            press_cnt   <= 8'd0;
        end else begin
            case (state)
                PR_IDLE: begin
                    if (press) begin
                        state       <= PR_PENDING;
                        req_pending <= 1'b1;
                        press_cnt   <= sat_inc8(press_cnt);
                    end
                end
                PR_PENDING: begin
                    casez (lamps)
                        3'b1??: begin
                            state       <= PR_IDLE;
                            req_pending <= 1'b0;
                        end
                        3'b01?: state <= PR_PENDING;
                        default: begin
                            state <= PR_FIRE;
                            pass  <= 1'b1;
                        end
                    endcase
                end
                PR_FIRE: begin
                    state       <= PR_COOLDOWN;
                    cd          <= CDW'(COOLDOWN_CYCLES - 1);
                    pass        <= 1'b0;
                    req_pending <= 1'b0;
                end
                PR_COOLDOWN: begin
                    if (cd == '0) begin
                        state <= PR_IDLE;
                    end else begin
                        cd <= cd - 1'b1;
                    end
                end
                default: begin
                    state       <= PR_IDLE;
                    pass        <= 1'b0;
                    req_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule
